// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: registers ALU results for writeback and runs
// LD/ST through a req/ack data-memory handshake with timeout and alignment trap.
module mem_access_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter bit          ALIGN_CHECK    = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] alu_rd_p1,
   input  logic        alu_output_valid,
   input  logic        ldst_valid_ix,
   input  logic        store_ix,
   input  logic [15:0] store_data_ix,
   input  logic        wb_en_ix,
   input  logic [2:0]  wb_reg_ix,
   input  logic        flush_ix,
   output logic        stall_ex,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [15:0] dmem_addr,
   output logic [15:0] dmem_wdata,
   input  logic [15:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        wb_valid,
   output logic        wb_en,
   output logic [2:0]  wb_reg,
   output logic [15:0] wb_data,
   output logic        mem_err
);

   typedef enum logic [1:0] {IDLE, ACCESS, WB} state_t;

   localparam logic [7:0] TMO_LIM = 8'(TIMEOUT_CYCLES);

   state_t      state_q, state_d;
   logic [15:0] addr_q, addr_d;
   logic        we_q, we_d;
   logic [15:0] wdata_q, wdata_d;
   logic [2:0]  reg_q, reg_d;
   logic        ld_wben_q, ld_wben_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  cnt_inc;
   logic        wb_valid_q, wb_valid_d;
   logic        wb_en_q, wb_en_d;
   logic [2:0]  wb_reg_q, wb_reg_d;
   logic [15:0] wb_data_q, wb_data_d;
   logic        mem_err_q, mem_err_d;

   assign cnt_inc = cnt_q + 8'd1;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      reg_d      = reg_q;
      ld_wben_d  = ld_wben_q;
      cnt_d      = cnt_q;
      wb_valid_d = 1'b0;
      wb_en_d    = 1'b0;
      mem_err_d  = 1'b0;
      wb_reg_d   = wb_reg_q;
      wb_data_d  = wb_data_q;
      case (state_q)
         IDLE: begin
            if (alu_output_valid && !flush_ix) begin
               if (!ldst_valid_ix) begin
                  wb_valid_d = 1'b1;
                  wb_en_d    = wb_en_ix;
                  wb_reg_d   = wb_reg_ix;
                  wb_data_d  = alu_rd_p1;
               end else if (ALIGN_CHECK && alu_rd_p1[0]) begin
                  wb_valid_d = 1'b1;
                  mem_err_d  = 1'b1;
                  wb_reg_d   = wb_reg_ix;
                  wb_data_d  = alu_rd_p1;
               end else begin
                  addr_d    = alu_rd_p1;
                  we_d      = store_ix;
                  wdata_d   = store_data_ix;
                  reg_d     = wb_reg_ix;
                  // Stores never write a register, so fold that in at latch time
                  ld_wben_d = wb_en_ix & ~store_ix;
                  cnt_d     = 8'd0;
                  state_d   = ACCESS;
               end
            end
         end
         ACCESS: begin
            cnt_d = cnt_inc;
            if (dmem_ack) begin
               state_d    = WB;
               wb_valid_d = 1'b1;
               wb_en_d    = ld_wben_q;
               wb_reg_d   = reg_q;
               wb_data_d  = we_q ? addr_q : dmem_rdata;
            end else if (cnt_inc == TMO_LIM) begin
               state_d    = WB;
               wb_valid_d = 1'b1;
               mem_err_d  = 1'b1;
               wb_reg_d   = reg_q;
               wb_data_d  = addr_q;
            end
         end
         WB:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         reg_q      <= '0;
         ld_wben_q  <= 1'b0;
         cnt_q      <= '0;
         wb_valid_q <= 1'b0;
         wb_en_q    <= 1'b0;
         wb_reg_q   <= '0;
         wb_data_q  <= '0;
         mem_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         reg_q      <= reg_d;
         ld_wben_q  <= ld_wben_d;
         cnt_q      <= cnt_d;
         wb_valid_q <= wb_valid_d;
         wb_en_q    <= wb_en_d;
         wb_reg_q   <= wb_reg_d;
         wb_data_q  <= wb_data_d;
         mem_err_q  <= mem_err_d;
      end
   end

   // Request and stall decode straight from state so reset clears them at once
   assign stall_ex   = (state_q != IDLE);
   assign dmem_req   = (state_q == ACCESS);
   assign dmem_we    = we_q;
   assign dmem_addr  = addr_q;
   assign dmem_wdata = wdata_q;
   assign wb_valid   = wb_valid_q;
   assign wb_en      = wb_en_q;
   assign wb_reg     = wb_reg_q;
   assign wb_data    = wb_data_q;
   assign mem_err    = mem_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage: each accepted instruction is expanded
// into a per-cycle schedule of expected outputs, compared every cycle.
module tb_mem_access_stage;
   localparam int TMO  = 4;
   localparam int NCYC = 4096;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] alu_rd_p1;
   logic        alu_output_valid, ldst_valid_ix, store_ix, wb_en_ix, flush_ix;
   logic [15:0] store_data_ix;
   logic [2:0]  wb_reg_ix;
   logic        stall_ex, dmem_req, dmem_we;
   logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        dmem_ack;
   logic        wb_valid, wb_en, mem_err;
   logic [2:0]  wb_reg;
   logic [15:0] wb_data;

   mem_access_stage #(.TIMEOUT_CYCLES(TMO), .ALIGN_CHECK(1'b1)) dut (
      .clk(clk), .rst(rst), .alu_rd_p1(alu_rd_p1), .alu_output_valid(alu_output_valid),
      .ldst_valid_ix(ldst_valid_ix), .store_ix(store_ix), .store_data_ix(store_data_ix),
      .wb_en_ix(wb_en_ix), .wb_reg_ix(wb_reg_ix), .flush_ix(flush_ix), .stall_ex(stall_ex),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .wb_valid(wb_valid), .wb_en(wb_en),
      .wb_reg(wb_reg), .wb_data(wb_data), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   bit        exp_stall[NCYC], exp_req[NCYC], exp_we[NCYC], exp_wbv[NCYC];
   bit        exp_wben[NCYC], exp_err[NCYC], chk_wd[NCYC], chk_wdata[NCYC];
   bit [15:0] exp_addr[NCYC], exp_wdata[NCYC], exp_data[NCYC];
   bit [2:0]  exp_reg[NCYC];

   int        cyc = 0, free_cyc = 1, ack_cyc = -1, win_lo = -1, win_hi = -2;
   bit [15:0] ack_data;
   int        checks = 0, errors = 0;
   int        reqcnt;

   task automatic chk(input string name, input int c, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got %h expected %h", name, c, got, exp);
      end
   endtask

   task automatic check_cycle(input int c);
      chk("stall_ex", c, 16'(stall_ex), 16'(exp_stall[c]));
      chk("dmem_req", c, 16'(dmem_req), 16'(exp_req[c]));
      chk("wb_valid", c, 16'(wb_valid), 16'(exp_wbv[c]));
      chk("wb_en",    c, 16'(wb_en),    16'(exp_wben[c]));
      chk("mem_err",  c, 16'(mem_err),  16'(exp_err[c]));
      if (exp_req[c]) begin
         chk("dmem_addr", c, dmem_addr, exp_addr[c]);
         chk("dmem_we",   c, 16'(dmem_we), 16'(exp_we[c]));
         if (chk_wdata[c]) chk("dmem_wdata", c, dmem_wdata, exp_wdata[c]);
      end
      if (exp_wbv[c] && chk_wd[c]) begin
         chk("wb_data", c, wb_data, exp_data[c]);
         chk("wb_reg",  c, 16'(wb_reg), 16'(exp_reg[c]));
      end
   endtask

   // One cycle: check outputs, play memory, present an instruction, extend the schedule.
   task automatic step(input bit v, input bit ls, input bit st, input bit [15:0] a,
                       input bit [15:0] sd, input bit we, input bit [2:0] r, input bit fl,
                       input int d, input bit [15:0] rd);
      int n;
      int w;
      @(posedge clk); #1;
      cyc++;
      check_cycle(cyc);
      if (cyc == ack_cyc) begin
         dmem_ack = 1'b1; dmem_rdata = ack_data;
      end else if (cyc >= win_lo && cyc <= win_hi) begin
         dmem_ack = 1'b0; dmem_rdata = 16'($urandom);
      end else begin
         dmem_ack = ($urandom_range(0, 2) == 0); dmem_rdata = 16'($urandom);
      end
      alu_output_valid = v; ldst_valid_ix = ls; store_ix = st; alu_rd_p1 = a;
      store_data_ix = sd; wb_en_ix = we; wb_reg_ix = r; flush_ix = fl;
      if (cyc >= free_cyc && v && !fl) begin
         if (!ls) begin
            exp_wbv[cyc+1] = 1'b1; exp_wben[cyc+1] = we; exp_data[cyc+1] = a;
            exp_reg[cyc+1] = r; chk_wd[cyc+1] = 1'b1;
            free_cyc = cyc + 1;
         end else if (a[0]) begin
            exp_wbv[cyc+1] = 1'b1; exp_err[cyc+1] = 1'b1;
            free_cyc = cyc + 1;
         end else begin
            n = (d > TMO) ? TMO : d;
            for (int i = 1; i <= n; i++) begin
               exp_req[cyc+i] = 1'b1; exp_stall[cyc+i] = 1'b1; exp_addr[cyc+i] = a;
               exp_we[cyc+i] = st; chk_wdata[cyc+i] = st; exp_wdata[cyc+i] = sd;
            end
            w = cyc + n + 1;
            exp_stall[w] = 1'b1; exp_wbv[w] = 1'b1;
            if (d > TMO) begin
               exp_err[w] = 1'b1; ack_cyc = -1;
            end else begin
               exp_wben[w] = st ? 1'b0 : we; exp_data[w] = st ? a : rd;
               exp_reg[w] = r; chk_wd[w] = 1'b1;
               ack_cyc = cyc + d; ack_data = rd;
            end
            win_lo = cyc + 1; win_hi = cyc + n; free_cyc = cyc + n + 2;
         end
      end
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 1'b0, 1, 16'h0);
   endtask

   task automatic wait_free();
      while (cyc + 1 < free_cyc) idle();
   endtask

   initial begin
      bit v, ls, st, we, fl;
      bit [15:0] a, sd, rd;
      bit [2:0] r;
      int d;
      rst = 1'b0; alu_rd_p1 = '0; alu_output_valid = 0; ldst_valid_ix = 0; store_ix = 0;
      store_data_ix = '0; wb_en_ix = 0; wb_reg_ix = '0; flush_ix = 0; dmem_rdata = '0; dmem_ack = 0;
      #1;
      chk("rst_stall", 0, 16'(stall_ex), 16'h0);
      chk("rst_req",   0, 16'(dmem_req), 16'h0);
      chk("rst_wbv",   0, 16'(wb_valid), 16'h0);
      chk("rst_err",   0, 16'(mem_err),  16'h0);
      chk("rst_addr",  0, dmem_addr,     16'h0);
      chk("rst_wdata", 0, wb_data,       16'h0);
      @(negedge clk); rst = 1'b1;

      // ALU op
      wait_free();
      step(1'b1, 1'b0, 1'b0, 16'h1234, 16'h0, 1'b1, 3'd3, 1'b0, 1, 16'h0);
      idle();
      chk("lit_alu_wbv",   cyc, 16'(wb_valid), 16'h1);
      chk("lit_alu_data",  cyc, wb_data, 16'h1234);
      chk("lit_alu_reg",   cyc, 16'(wb_reg), 16'h3);
      chk("lit_alu_stall", cyc, 16'(stall_ex), 16'h0);

      // LD with ack in third access cycle
      wait_free();
      step(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0, 1'b1, 3'd2, 1'b0, 3, 16'hBEEF);
      reqcnt = 0;
      repeat (4) begin
         idle();
         if (dmem_req) reqcnt++;
      end
      chk("lit_ld_reqcnt", cyc, 16'(reqcnt), 16'd3);
      chk("lit_ld_wbv",    cyc, 16'(wb_valid), 16'h1);
      chk("lit_ld_data",   cyc, wb_data, 16'hBEEF);

      // ST acked immediately, then back-to-back ALU op
      wait_free();
      step(1'b1, 1'b1, 1'b1, 16'h0100, 16'hA5A5, 1'b1, 3'd1, 1'b0, 1, 16'h0);
      idle();
      chk("lit_st_req",   cyc, 16'(dmem_req), 16'h1);
      chk("lit_st_we",    cyc, 16'(dmem_we), 16'h1);
      chk("lit_st_wdata", cyc, dmem_wdata, 16'hA5A5);
      idle();
      chk("lit_st_wbv",   cyc, 16'(wb_valid), 16'h1);
      chk("lit_st_wben",  cyc, 16'(wb_en), 16'h0);
      step(1'b1, 1'b0, 1'b0, 16'h0777, 16'h0, 1'b1, 3'd5, 1'b0, 1, 16'h0);
      idle();
      chk("lit_b2b_data", cyc, wb_data, 16'h0777);

      // Misaligned LD
      wait_free();
      step(1'b1, 1'b1, 1'b0, 16'h0041, 16'h0, 1'b1, 3'd4, 1'b0, 1, 16'h0);
      idle();
      chk("lit_mis_req",  cyc, 16'(dmem_req), 16'h0);
      chk("lit_mis_wbv",  cyc, 16'(wb_valid), 16'h1);
      chk("lit_mis_wben", cyc, 16'(wb_en), 16'h0);
      chk("lit_mis_err",  cyc, 16'(mem_err), 16'h1);

      // Timeout
      wait_free();
      step(1'b1, 1'b1, 1'b0, 16'h0200, 16'h0, 1'b1, 3'd6, 1'b0, 99, 16'h0);
      reqcnt = 0;
      repeat (5) begin
         idle();
         if (dmem_req) reqcnt++;
      end
      chk("lit_tmo_reqcnt", cyc, 16'(reqcnt), 16'd4);
      chk("lit_tmo_err",    cyc, 16'(mem_err), 16'h1);
      chk("lit_tmo_wben",   cyc, 16'(wb_en), 16'h0);
      repeat (3) idle();

      // Flushed LD
      wait_free();
      step(1'b1, 1'b1, 1'b0, 16'h0080, 16'h0, 1'b1, 3'd1, 1'b1, 1, 16'h0);
      idle();
      chk("lit_flush_req", cyc, 16'(dmem_req), 16'h0);
      chk("lit_flush_wbv", cyc, 16'(wb_valid), 16'h0);

      // Random traffic, including garbage presented while stalled
      repeat (2500) begin
         v  = ($urandom_range(0, 3) != 0);
         ls = $urandom_range(0, 1) == 1;
         st = $urandom_range(0, 1) == 1;
         a  = 16'($urandom);
         if ($urandom_range(0, 3) != 0) a[0] = 1'b0;
         sd = 16'($urandom);
         we = $urandom_range(0, 1) == 1;
         r  = 3'($urandom);
         fl = ($urandom_range(0, 7) == 0);
         d  = $urandom_range(1, 6);
         rd = 16'($urandom);
         step(v, ls, st, a, sd, we, r, fl, d, rd);
      end

      // Reset in the middle of an access
      wait_free();
      step(1'b1, 1'b1, 1'b1, 16'h0300, 16'h1111, 1'b0, 3'd0, 1'b0, 99, 16'h0);
      idle();
      idle();
      chk("lit_rst_pre_req", cyc, 16'(dmem_req), 16'h1);
      #2 rst = 1'b0;
      #1;
      chk("lit_rst_req",   cyc, 16'(dmem_req), 16'h0);
      chk("lit_rst_stall", cyc, 16'(stall_ex), 16'h0);
      chk("lit_rst_wbv",   cyc, 16'(wb_valid), 16'h0);
      @(posedge clk); #1;
      chk("lit_rst_hold_wbv", cyc, 16'(wb_valid), 16'h0);
      chk("lit_rst_hold_err", cyc, 16'(mem_err), 16'h0);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("lit_post_rst_req", cyc, 16'(dmem_req), 16'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
